// File: rtl/button_reader_if.sv
// Push-button reader bus: raw button level in, debounced level, press count and strobes out.
interface button_reader_if;
  localparam int unsigned LED_W = 4;

  logic             btn;
  logic [LED_W-1:0] leds;
  logic             press_pulse;
  logic             long_pulse;
  logic             pressed;

  modport master (
    output btn,
    input  leds,
    input  press_pulse,
    input  long_pulse,
    input  pressed
  );

  modport slave (
    input  btn,
    output leds,
    output press_pulse,
    output long_pulse,
    output pressed
  );
endinterface

// File: rtl/button_reader.sv
// Debounced push-button reader: counts short presses on leds, flags a long hold once,
// and clears the count when a long press fires.
module button_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic           clk,
  input  logic           rst,
  button_reader_if.slave bus
);

  localparam int unsigned LED_W  = 4;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  logic              r_sync1;
  logic              r_sync2;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_pressed;

  state_e            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [LED_W-1:0]  r_leds;
  logic              r_press;
  logic              r_long;

  logic              w_differs;
  logic              w_accept;
  logic              w_rise;
  logic              w_fall;

  state_e            w_state_nx;
  logic [HOLD_W-1:0] w_hold_nx;
  logic [LED_W-1:0]  w_leds_nx;
  logic              w_press_nx;
  logic              w_long_nx;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differs = (r_sync2 != r_pressed);
  assign w_accept  = w_differs && (r_db_cnt == DB_LAST);
  assign w_rise    = w_accept && !r_pressed;
  assign w_fall    = w_accept && r_pressed;

  // Debounce: a change must persist DEBOUNCE_CYCLES edges; any bounce back restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt  <= '0;
      r_pressed <= 1'b0;
    end else if (!w_differs) begin
      r_db_cnt  <= '0;
    end else if (w_accept) begin
      r_db_cnt  <= '0;
      r_pressed <= ~r_pressed;
    end else begin
      r_db_cnt  <= r_db_cnt + DB_W'(1);
    end
  end

  // Press FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_leds  <= '0;
      r_press <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_hold  <= w_hold_nx;
      r_leds  <= w_leds_nx;
      r_press <= w_press_nx;
      r_long  <= w_long_nx;
    end
  end

  // A long press that matures on the same edge as the release still fires once
  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold;
    w_leds_nx  = r_leds;
    w_press_nx = 1'b0;
    w_long_nx  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_hold_nx = '0;
        if (w_rise) begin
          w_state_nx = ST_DOWN;
          w_press_nx = 1'b1;
          w_leds_nx  = r_leds + LED_W'(1);
        end
      end
      ST_DOWN: begin
        if (r_hold == HOLD_LAST) begin
          w_long_nx  = 1'b1;
          w_leds_nx  = '0;
          w_hold_nx  = '0;
          w_state_nx = w_fall ? ST_IDLE : ST_HELD;
        end else if (w_fall) begin
          w_hold_nx  = '0;
          w_state_nx = ST_IDLE;
        end else begin
          w_hold_nx  = r_hold + HOLD_W'(1);
        end
      end
      ST_HELD: begin
        w_hold_nx = '0;
        if (w_fall) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_hold_nx  = '0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign bus.leds        = r_leds;
  assign bus.press_pulse = r_press;
  assign bus.long_pulse  = r_long;
  assign bus.pressed     = r_pressed;

endmodule
